// File: rtl/pdm_interp_pkg.sv
// Shared types and constants for the stereo linear interpolator feeding the PDM DAC.
// Per-lane widths derive from SAMPLE_W, DELTA_W and the instance's LOG2_OSR.
package pdm_interp_pkg;

    localparam int unsigned LOG2_OSR_DEF  = 4;
    localparam int unsigned STEP_CLKS_DEF = 16;

    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned DELTA_W   = SAMPLE_W + 1;
    localparam int unsigned ACC_W_DEF = DELTA_W + LOG2_OSR_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/pdm_interp_lane.sv
// One-channel interpolation datapath: latches the segment endpoints and walks a
// fixed-point accumulator from the previous sample toward the new one.
module pdm_interp_lane
    import pdm_interp_pkg::*;
#(
    parameter int unsigned LOG2_OSR = LOG2_OSR_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_seg,
    input  logic                       step,
    input  logic                       hold,
    input  logic signed [SAMPLE_W-1:0] x_in,
    output logic signed [SAMPLE_W-1:0] x_out
);

    localparam int unsigned ACC_W = DELTA_W + LOG2_OSR;

    logic signed [SAMPLE_W-1:0] x_cur;
    logic signed [DELTA_W-1:0]  delta;
    logic signed [ACC_W-1:0]    acc;

    // The previous sample is never stored separately: acc is seeded with it
    // and the k=0 output reads it straight back out of acc.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_cur <= '0;
            delta <= '0;
            acc   <= '0;
            x_out <= '0;
        end else if (load_seg) begin
            x_cur <= x_in;
            delta <= {x_in[SAMPLE_W-1], x_in} - {x_cur[SAMPLE_W-1], x_cur};
            acc   <= {{(ACC_W-SAMPLE_W-LOG2_OSR){x_cur[SAMPLE_W-1]}}, x_cur, {LOG2_OSR{1'b0}}};
        end else if (step) begin
            // Slicing above the fraction bits is an arithmetic floor shift.
            x_out <= acc[LOG2_OSR +: SAMPLE_W];
            acc   <= acc + {{LOG2_OSR{delta[DELTA_W-1]}}, delta};
        end else if (hold) begin
            x_out <= x_cur;
        end
    end

endmodule

// File: rtl/pdm_interp.sv
// Stereo linear interpolator: shared FSM and step counter drive two lane datapaths
// that emit 2^LOG2_OSR interpolated sample pairs per input period.
module pdm_interp
    import pdm_interp_pkg::*;
#(
    parameter int unsigned LOG2_OSR  = LOG2_OSR_DEF,
    parameter int unsigned STEP_CLKS = STEP_CLKS_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_load,
    input  logic signed [SAMPLE_W-1:0] lin,
    input  logic signed [SAMPLE_W-1:0] rin,
    input  logic                       clr_err,
    output logic                       out_load,
    output logic signed [SAMPLE_W-1:0] lout,
    output logic signed [SAMPLE_W-1:0] rout,
    output logic                       err_early,
    output logic                       err_late
);

    localparam int unsigned CNT_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [LOG2_OSR-1:0] k;
    logic                first_hold;
    logic                tick;
    logic                step;
    logic                hold;

    // A new input sample always pre-empts a step tick landing on the same cycle.
    always_comb begin
        tick = (state != IDLE) && (cnt == '0);
        step = tick && !in_load && (state == RUN);
        hold = tick && !in_load && (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            k          <= '0;
            first_hold <= 1'b0;
            out_load   <= 1'b0;
            err_early  <= 1'b0;
            err_late   <= 1'b0;
        end else begin
            out_load <= step || hold;

            if (in_load) begin
                state      <= RUN;
                cnt        <= '0;
                k          <= '0;
                first_hold <= 1'b0;
            end else begin
                if (state != IDLE)
                    cnt <= (cnt == CNT_W'(STEP_CLKS - 1)) ? '0 : cnt + 1'b1;
                if (step) begin
                    k <= k + 1'b1;
                    if (k == '1) begin
                        state      <= HOLD;
                        first_hold <= 1'b1;
                    end
                end
                if (hold)
                    first_hold <= 1'b0;
            end

            if (in_load && (state == RUN))
                err_early <= 1'b1;
            else if (clr_err)
                err_early <= 1'b0;

            if (hold && first_hold)
                err_late <= 1'b1;
            else if (clr_err)
                err_late <= 1'b0;
        end
    end

    pdm_interp_lane #(
        .LOG2_OSR (LOG2_OSR)
    ) u_lane_l (
        .clk      (clk),
        .reset    (reset),
        .load_seg (in_load),
        .step     (step),
        .hold     (hold),
        .x_in     (lin),
        .x_out    (lout)
    );

    pdm_interp_lane #(
        .LOG2_OSR (LOG2_OSR)
    ) u_lane_r (
        .clk      (clk),
        .reset    (reset),
        .load_seg (in_load),
        .step     (step),
        .hold     (hold),
        .x_in     (rin),
        .x_out    (rout)
    );

endmodule

// File: tb/tb_pdm_interp.sv
// Directed bench for pdm_interp: ramps, full-scale step, late/early input timing,
// and reset mid-segment, all against hand-computed expected values.
module tb_pdm_interp;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_load;
    logic signed [15:0] lin;
    logic signed [15:0] rin;
    logic               clr_err;
    logic               out_load;
    logic signed [15:0] lout;
    logic signed [15:0] rout;
    logic               err_early;
    logic               err_late;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int k;
        int exp_l;
        int exp_r;
    } vec_t;

    vec_t fs[5];

    always #5 clk = ~clk;

    pdm_interp #(
        .LOG2_OSR  (4),
        .STEP_CLKS (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_load   (in_load),
        .lin       (lin),
        .rin       (rin),
        .clr_err   (clr_err),
        .out_load  (out_load),
        .lout      (lout),
        .rout      (rout),
        .err_early (err_early),
        .err_late  (err_late)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int l, input int r);
        lin     = 16'(l);
        rin     = 16'(r);
        in_load = 1'b1;
        @(negedge clk);
        in_load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits (bounded) for the next out_load; n = negedges elapsed.
    task automatic wait_strobe(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_load && n < 300);
        check({name, " strobe"}, int'(out_load), 1);
    endtask

    initial begin
        int g;
        int j;
        int cnt;

        fs[0] = '{k: 0,  exp_l: -32768, exp_r: 1600};
        fs[1] = '{k: 1,  exp_l: -28673, exp_r: 1400};
        fs[2] = '{k: 2,  exp_l: -24577, exp_r: 1200};
        fs[3] = '{k: 8,  exp_l: -1,     exp_r: 0};
        fs[4] = '{k: 15, exp_l: 28671,  exp_r: -1400};

        reset   = 1'b0;
        in_load = 1'b0;
        clr_err = 1'b0;
        lin     = '0;
        rin     = '0;
        tick_n(3);
        check("rst out_load", int'(out_load), 0);
        check("rst lout", int'(lout), 0);
        check("rst rout", int'(rout), 0);
        check("rst err_early", int'(err_early), 0);
        check("rst err_late", int'(err_late), 0);
        reset = 1'b1;
        tick_n(2);

        // Ramp 0 -> 1600 / 0 -> -1600, then a flat segment at the target.
        do_load(1600, -1600);
        for (int k = 0; k < 16; k++) begin
            wait_strobe($sformatf("ramp k%0d", k), g);
            check($sformatf("ramp k%0d gap", k), g, (k == 0) ? 1 : 16);
            check($sformatf("ramp k%0d lout", k), int'(lout), 100 * k);
            check($sformatf("ramp k%0d rout", k), int'(rout), -100 * k);
        end
        tick_n(14);
        do_load(1600, -1600);
        for (int k = 0; k < 16; k++) begin
            wait_strobe($sformatf("flat k%0d", k), g);
            check($sformatf("flat k%0d gap", k), g, (k == 0) ? 1 : 16);
            check($sformatf("flat k%0d lout", k), int'(lout), 1600);
            check($sformatf("flat k%0d rout", k), int'(rout), -1600);
        end
        check("flat err_early", int'(err_early), 0);
        check("flat err_late", int'(err_late), 0);

        // Full-scale step -32768 -> 32767 (right: 1600 -> -1600).
        do_reset();
        do_load(-32768, 1600);
        tick_n(255);
        do_load(32767, -1600);
        j = 0;
        for (int k = 0; k < 16; k++) begin
            wait_strobe($sformatf("fs k%0d", k), g);
            check($sformatf("fs k%0d gap", k), g, (k == 0) ? 1 : 16);
            if (j < 5 && fs[j].k == k) begin
                check($sformatf("fs k%0d lout", k), int'(lout), fs[j].exp_l);
                check($sformatf("fs k%0d rout", k), int'(rout), fs[j].exp_r);
                j++;
            end
        end
        check("fs err_early", int'(err_early), 0);
        check("fs err_late", int'(err_late), 0);

        // Late input: segment finishes, HOLD strobes repeat x_cur.
        do_reset();
        do_load(500, -500);
        for (int k = 0; k < 16; k++) begin
            wait_strobe($sformatf("late k%0d", k), g);
            check($sformatf("late k%0d gap", k), g, (k == 0) ? 1 : 16);
        end
        check("late k15 lout", int'(lout), 468);
        check("late k15 rout", int'(rout), -469);
        check("late k15 err_late", int'(err_late), 0);
        wait_strobe("hold1", g);
        check("hold1 gap", g, 16);
        check("hold1 lout", int'(lout), 500);
        check("hold1 rout", int'(rout), -500);
        check("hold1 err_late", int'(err_late), 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr err_late", int'(err_late), 0);
        wait_strobe("hold2", g);
        check("hold2 lout", int'(lout), 500);
        check("hold2 err_late", int'(err_late), 0);

        // Early input coinciding with a step tick: tick suppressed.
        do_reset();
        do_load(1000, 2000);
        tick_n(96);
        check("pre-early err_early", int'(err_early), 0);
        do_load(-1000, -2000);
        check("suppressed tick", int'(out_load), 0);
        wait_strobe("early k0", g);
        check("early k0 gap", g, 1);
        check("early k0 lout", int'(lout), 1000);
        check("early k0 rout", int'(rout), 2000);
        check("early err_early", int'(err_early), 1);
        wait_strobe("early k1", g);
        check("early k1 gap", g, 16);
        check("early k1 lout", int'(lout), 875);
        check("early k1 rout", int'(rout), 1750);

        // Reset mid-RUN at k=7; clr_err coincident with an early load keeps the flag set.
        do_reset();
        do_load(1600, -1600);
        tick_n(17);
        clr_err = 1'b1;
        do_load(800, -800);
        clr_err = 1'b0;
        check("set-wins err_early", int'(err_early), 1);
        for (int k = 0; k < 8; k++) begin
            wait_strobe($sformatf("mid k%0d", k), g);
            check($sformatf("mid k%0d gap", k), g, (k == 0) ? 1 : 16);
        end
        check("mid k7 lout", int'(lout), 1250);
        check("mid k7 rout", int'(rout), -1250);
        reset = 1'b0;
        @(negedge clk);
        check("mid rst out_load", int'(out_load), 0);
        check("mid rst lout", int'(lout), 0);
        check("mid rst rout", int'(rout), 0);
        check("mid rst err_early", int'(err_early), 0);
        check("mid rst err_late", int'(err_late), 0);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_load) cnt++;
        end
        check("idle strobes", cnt, 0);
        do_load(160, -160);
        wait_strobe("post k0", g);
        check("post k0 gap", g, 1);
        check("post k0 lout", int'(lout), 0);
        check("post k0 rout", int'(rout), 0);
        wait_strobe("post k1", g);
        check("post k1 lout", int'(lout), 10);
        check("post k1 rout", int'(rout), -10);
        check("post err_early", int'(err_early), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdm_interp.md
Name: pdm_interp

Overview:
- Stereo linear interpolator that sits directly upstream of the sigma-delta PDM DAC.
- Accepts 16-bit signed L/R audio samples at the input rate, marked by a one-clock in_load strobe.
- Emits 2^LOG2_OSR linearly interpolated sample pairs per input period, each marked by an out_load strobe, so the DAC modulator runs on upsampled data instead of zero-order-held samples.
- Also reports input timing faults (early and late input strobes) through sticky flags.

Parameters:
- LOG2_OSR, 4: log2 of the upsampling ratio; outputs per input sample = 2^LOG2_OSR.
- STEP_CLKS, 16: clk cycles between output strobes. Nominal input period = STEP_CLKS << LOG2_OSR = 256 clk, i.e. 46.875 kHz at 12 MHz.

Ports:
- clk  in  1  system clock, 12 MHz.
- reset  in  1  synchronous, active-low reset.
- in_load  in  1  one-clock strobe; lin/rin are valid on this cycle.
- lin  in  16  signed left input sample.
- rin  in  16  signed right input sample.
- clr_err  in  1  one-clock strobe; clears err_early and err_late.
- out_load  out  1  one-clock strobe; lout/rout are updated on this cycle.
- lout  out  16  signed interpolated left sample.
- rout  out  16  signed interpolated right sample.
- err_early  out  1  sticky: in_load arrived before the segment completed.
- err_late  out  1  sticky: segment completed with no new in_load.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; x_prev=x_cur=0; acc=0; k=0; step counter=0; out_load=0; lout=rout=0; err flags=0.
- States:
  - IDLE: no out_load; wait for in_load.
  - RUN: emit interpolated outputs.
  - HOLD: segment finished; repeat x_cur.
- in_load at cycle t, in any state:
  - x_prev <= x_cur; x_cur <= {lin,rin}; delta <= x_in - x_cur (17-bit signed); acc <= x_cur <<< LOG2_OSR (17+LOG2_OSR bits, signed); k <= 0; step counter <= 0; state <= RUN.
  - Captures happen at t+1.
  - First out_load (k=0, value x_prev) occurs at cycle t+2. Latency in_load -> first out_load is 2 clk.
- RUN:
  - out_load fires every STEP_CLKS clk.
  - Output value is acc >>> LOG2_OSR (arithmetic shift, floor), then acc += delta.
  - Output k equals x_prev + floor(k*delta / 2^LOG2_OSR), for k = 0 .. 2^LOG2_OSR-1. No overflow is possible, so the 16-bit truncation is exact.
  - After output k = 2^LOG2_OSR-1 is emitted: state <= HOLD.
- HOLD:
  - out_load continues at STEP_CLKS spacing with lout/rout = x_cur.
  - The first HOLD strobe sets err_late.
- Early in_load: in_load in RUN before output k = 2^LOG2_OSR-1 has been emitted sets err_early. The new segment still starts from the latched x_cur (the old target), not from the current interpolated value.
- in_load and a pending step tick on the same cycle: in_load wins, the tick is suppressed, and the new segment's k=0 strobe follows at t+2.
- in_load in IDLE: x_prev = 0, so the first segment ramps from 0. err_early is not set.
- clr_err and a flag-setting event on the same cycle: the set wins.
- lout/rout are held between strobes. out_load is never asserted for two consecutive clk unless STEP_CLKS=1.
- Reset mid-segment: immediate return to the reset values above; no out_load on the reset cycle.
- L and R share all control logic and differ only in datapath.

Decomposition:
- Package pdm_interp_pkg holds:
  - the state enum (IDLE, RUN, HOLD);
  - SAMPLE_W=16, DELTA_W=17, ACC_W = DELTA_W + LOG2_OSR;
  - the default LOG2_OSR and STEP_CLKS constants.
- Sub-module pdm_interp_lane: one-channel datapath (x_prev/x_cur/delta/acc registers and output register).
  - Driven by the shared strobes load_seg, step and hold from the top-level FSM/counter.
  - Instantiated twice, for L and R.

Test Plan:
- Reset, then in_load with lin=1600, rin=-1600, with further in_load every 256 clk holding the same values.
  - Expect lout = 0,100,...,1500 (rout = 0,-100,...,-1500) on out_load strobes at t+2+16k.
  - Next segment: lout = 1600 constant. No error flags.
- Full-scale step: lin=-32768, then lin=32767 one period later.
  - Expect k=0 output -32768, k=1 output -28673 (floor).
  - Final (k=15) output 28671; no wrap.
- Late input: after one in_load, withhold in_load for 400 clk.
  - Expect 16 RUN strobes, then HOLD strobes at 16-clk spacing with x_cur.
  - err_late=1 at the first HOLD strobe.
  - clr_err clears it.
- Early input: second in_load 100 clk after the first.
  - Expect err_early=1. The new segment's k=0 equals the first sample, at t+2.
  - The suppressed tick produces no extra strobe.
- Reset asserted (reset=0) mid-RUN at k=7.
  - Expect the next cycle to show out_load=0, lout=rout=0, flags=0, state IDLE.
  - No strobes until the next in_load.
